// File: rtl/divisor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divisor_pkg
// Purpose  : Shared types, constants and helpers for the multi-channel
//            clock-enable generator.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
package divisor_pkg;

    // Output behaviour of a channel: single-cycle tick or 50 % square enable.
    typedef enum logic {
        MODE_PULSE  = 1'b0,
        MODE_SQUARE = 1'b1
    } mode_e;

    // Terminal value every channel starts from (legacy 24-bit divisor value).
    localparam int DEFAULT_DIV = 12500000;

    // Width of a channel index; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/divisor_channel.sv
`default_nettype none
// ============================================================================
// Module   : divisor_channel
// Purpose  : One divider slice: period counter, deferred-load shadow and the
//            registered pulse/square output.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module divisor_channel #(
    parameter int WIDTH       = 24,
    parameter int DEFAULT_DIV = 12500000
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             ce,
    input  logic             en,
    input  logic             load,
    input  logic             load_imm,
    input  logic [WIDTH-1:0] load_div,
    input  logic             load_mode,
    output logic             tick,
    output logic             pending
);
    import divisor_pkg::*;

    localparam logic [WIDTH-1:0] c_reset_div = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_sh_div;
    mode_e            r_mode;
    mode_e            r_sh_mode;
    logic             r_pending;
    logic             r_out;

    logic             w_terminal;
    logic [WIDTH-1:0] w_wrap_div;
    mode_e            w_wrap_mode;
    logic             w_wrap_out;

    // Terminal detection and the values the channel adopts at a wrap
    // (a pending shadow takes over exactly at the wrap).
    always_comb begin
        w_terminal  = (r_count == r_div);
        w_wrap_div  = r_pending ? r_sh_div  : r_div;
        w_wrap_mode = r_pending ? r_sh_mode : r_mode;
        w_wrap_out  = 1'b0;
        if (w_wrap_mode == MODE_PULSE) begin
            w_wrap_out = 1'b1;
        end else if (w_wrap_mode == r_mode) begin
            w_wrap_out = ~r_out;
        end else begin
            // Entering square mode always starts from a low level.
            w_wrap_out = 1'b0;
        end
    end

    // Counter, shadow and output update; reset, then immediate loads, win.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_count   <= '0;
            r_div     <= c_reset_div;
            r_mode    <= MODE_PULSE;
            r_sh_div  <= c_reset_div;
            r_sh_mode <= MODE_PULSE;
            r_pending <= 1'b0;
            r_out     <= 1'b0;
        end else if (load && load_imm) begin
            r_div     <= load_div;
            r_mode    <= mode_e'(load_mode);
            r_count   <= '0;
            r_out     <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            if (!en) begin
                // A disabled channel has no wrap to wait for: flush the shadow.
                r_count <= '0;
                r_out   <= 1'b0;
                if (r_pending) begin
                    r_div  <= r_sh_div;
                    r_mode <= r_sh_mode;
                end
                r_pending <= 1'b0;
            end else if (!ce) begin
                // Frozen: a pulse must not stretch, a square level is kept.
                if (r_mode == MODE_PULSE) begin
                    r_out <= 1'b0;
                end
            end else if (w_terminal) begin
                r_count   <= '0;
                r_div     <= w_wrap_div;
                r_mode    <= w_wrap_mode;
                r_out     <= w_wrap_out;
                r_pending <= 1'b0;
            end else begin
                r_count <= r_count + c_one;
                if (r_mode == MODE_PULSE) begin
                    r_out <= 1'b0;
                end
            end
            // A deferred load lands after any wrap above, so it waits for the next one.
            if (load) begin
                r_sh_div  <= load_div;
                r_sh_mode <= mode_e'(load_mode);
                r_pending <= 1'b1;
            end
        end
    end

    assign tick    = r_out;
    assign pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/divisor_multi.sv
`default_nettype none
// ============================================================================
// Module   : divisor_multi
// Purpose  : Multi-channel runtime-programmable clock-enable generator.
//            Decodes and range-checks load requests, acknowledges them and
//            fans them out to the per-channel divider slices.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module divisor_multi #(
    parameter int WIDTH       = 24,
    parameter int CHANNELS    = 2,
    parameter int DEFAULT_DIV = divisor_pkg::DEFAULT_DIV
) (
    input  logic                                        iClk,
    input  logic                                        iReset,
    input  logic                                        iCE,
    input  logic [CHANNELS-1:0]                         ivChEn,
    input  logic                                        iLoad,
    input  logic [divisor_pkg::sel_width(CHANNELS)-1:0] ivLoadCh,
    input  logic [WIDTH-1:0]                            ivLoadDiv,
    input  logic                                        iLoadMode,
    input  logic                                        iLoadImm,
    output logic [CHANNELS-1:0]                         ovTick,
    output logic [CHANNELS-1:0]                         ovPending,
    output logic                                        oLoadAck
);
    localparam int              SEL_W      = divisor_pkg::sel_width(CHANNELS);
    localparam logic [SEL_W:0]  c_channels = (SEL_W + 1)'(CHANNELS);

    logic w_load_valid;
    logic r_load_ack;

    // A load naming a channel that does not exist is dropped silently.
    assign w_load_valid = iLoad && ({1'b0, ivLoadCh} < c_channels);

    // Acknowledge every accepted load one cycle after it is sampled.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_load_ack <= 1'b0;
        end else begin
            r_load_ack <= w_load_valid;
        end
    end

    assign oLoadAck = r_load_ack;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
        logic w_hit;

        assign w_hit = w_load_valid && (ivLoadCh == SEL_W'(g));

        divisor_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .iClk      (iClk),
            .iReset    (iReset),
            .ce        (iCE),
            .en        (ivChEn[g]),
            .load      (w_hit),
            .load_imm  (iLoadImm),
            .load_div  (ivLoadDiv),
            .load_mode (iLoadMode),
            .tick      (ovTick[g]),
            .pending   (ovPending[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_divisor_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_divisor_multi
// Purpose  : Self-checking bench for divisor_multi (vector table, directed
//            corner sequences, randomized traffic against a reference model).
// Revision : 1.0
// ============================================================================
module tb_divisor_multi;
    localparam int W    = 8;
    localparam int CH   = 3;
    localparam int DDIV = 4;
    localparam int NTBL = 18;

    logic          clk = 1'b0;
    logic          rst, ce, load, ld_mode, ld_imm;
    logic [CH-1:0] chen;
    logic [1:0]    ld_ch;
    logic [W-1:0]  ld_div;
    logic [CH-1:0] tick, pend;
    logic          ack;

    always #5 clk = ~clk;

    divisor_multi #(
        .WIDTH       (W),
        .CHANNELS    (CH),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .iClk      (clk),
        .iReset    (rst),
        .iCE       (ce),
        .ivChEn    (chen),
        .iLoad     (load),
        .ivLoadCh  (ld_ch),
        .ivLoadDiv (ld_div),
        .iLoadMode (ld_mode),
        .iLoadImm  (ld_imm),
        .ovTick    (tick),
        .ovPending (pend),
        .oLoadAck  (ack)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: elapsed cycles in the current period, period length
    // is div+1, plus shadow and output level per channel.
    int m_phase[CH];
    int m_div[CH];
    int m_sdiv[CH];
    bit m_sq[CH];
    bit m_ssq[CH];
    bit m_pend[CH];
    bit m_out[CH];
    bit m_ack;

    typedef struct packed {
        bit          rst;
        bit          load;
        bit [1:0]    ch;
        bit [W-1:0]  div;
        bit          mode;
        bit          imm;
        bit [CH-1:0] etick;
        bit [CH-1:0] epend;
        bit          eack;
    } vec_t;

    vec_t tbl[NTBL];

    task automatic model_edge();
        bit in_range;
        bit hit;
        bit old_sq;
        in_range = (int'(ld_ch) < CH);
        m_ack    = !rst && load && in_range;
        for (int c = 0; c < CH; c++) begin
            hit = load && in_range && (int'(ld_ch) == c);
            if (rst) begin
                m_phase[c] = 0; m_div[c] = DDIV; m_sq[c] = 0;
                m_pend[c]  = 0; m_out[c] = 0;
            end else if (hit && ld_imm) begin
                m_div[c] = int'(ld_div); m_sq[c] = ld_mode;
                m_phase[c] = 0; m_out[c] = 0; m_pend[c] = 0;
            end else begin
                if (!chen[c]) begin
                    m_phase[c] = 0; m_out[c] = 0;
                    if (m_pend[c]) begin m_div[c] = m_sdiv[c]; m_sq[c] = m_ssq[c]; end
                    m_pend[c] = 0;
                end else if (ce) begin
                    if (m_phase[c] + 1 == m_div[c] + 1) begin
                        old_sq = m_sq[c];
                        if (m_pend[c]) begin
                            m_div[c] = m_sdiv[c]; m_sq[c] = m_ssq[c]; m_pend[c] = 0;
                        end
                        m_phase[c] = 0;
                        if (!m_sq[c])   m_out[c] = 1;
                        else if (old_sq) m_out[c] = !m_out[c];
                        else            m_out[c] = 0;
                    end else begin
                        m_phase[c]++;
                        if (!m_sq[c]) m_out[c] = 0;
                    end
                end else if (!m_sq[c]) begin
                    m_out[c] = 0;
                end
                if (hit) begin
                    m_sdiv[c] = int'(ld_div); m_ssq[c] = ld_mode; m_pend[c] = 1;
                end
            end
        end
    endtask

    function automatic logic [CH-1:0] m_tick_vec();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_out[c];
        return v;
    endfunction

    function automatic logic [CH-1:0] m_pend_vec();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_pend[c];
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("model_tick", 8'(tick), 8'(m_tick_vec()));
        chk("model_pend", 8'(pend), 8'(m_pend_vec()));
        chk("model_ack",  8'(ack),  8'(m_ack));
    endtask

    // One clock edge: model follows the same sampled inputs; outputs are read 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        bit found;
        bit prev;
        rst = 1'b1; ce = 1'b1; chen = '1; load = 1'b0;
        ld_ch = '0; ld_div = '0; ld_mode = 1'b0; ld_imm = 1'b0;

        // ---- vector table: reset, first pulses, immediate square load, bad index
        for (int i = 0; i < NTBL; i++) tbl[i] = '0;
        tbl[0].rst   = 1'b1;
        tbl[5].etick = 3'b111;
        tbl[7].load  = 1'b1; tbl[7].ch = 2'd1; tbl[7].div = 8'd2;
        tbl[7].mode  = 1'b1; tbl[7].imm = 1'b1; tbl[7].eack = 1'b1;
        tbl[10].etick = 3'b111;
        tbl[11].etick = 3'b010;
        tbl[12].etick = 3'b010;
        tbl[15].etick = 3'b101;
        tbl[16].load = 1'b1; tbl[16].ch = 2'd3; tbl[16].div = 8'd0; tbl[16].imm = 1'b1;
        tbl[16].etick = 3'b010;
        tbl[17].etick = 3'b010;

        for (int i = 0; i < NTBL; i++) begin
            rst = tbl[i].rst; load = tbl[i].load; ld_ch = tbl[i].ch;
            ld_div = tbl[i].div; ld_mode = tbl[i].mode; ld_imm = tbl[i].imm;
            step();
            chk("tbl_tick", 8'(tick), 8'(tbl[i].etick));
            chk("tbl_pend", 8'(pend), 8'(tbl[i].epend));
            chk("tbl_ack",  8'(ack),  8'(tbl[i].eack));
        end
        rst = 1'b0; load = 1'b0;

        // ---- deferred load ch0 P=7, overwritten by P=1 before the wrap
        load = 1'b1; ld_ch = 2'd0; ld_div = 8'd7; ld_mode = 1'b0; ld_imm = 1'b0;
        step();
        chk("defer_pend_rise", 8'(pend[0]), 8'd1);
        chk("defer_ack", 8'(ack), 8'd1);
        ld_div = 8'd1;
        step();
        load = 1'b0;
        chk("defer_pend_hold", 8'(pend[0]), 8'd1);
        step();
        chk("defer_pend_clear", 8'(pend[0]), 8'd0);
        chk("defer_old_wrap_tick", 8'(tick[0]), 8'd1);
        for (int n = 0; n < 8; n++) begin step(); check_model(); end

        // ---- iCE low for 10 cycles starting in a pulse cycle
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            step(); check_model();
            if (tick[0]) found = 1'b1;
        end
        chk("wait_tick0", 8'(found), 8'd1);
        ce = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step(); check_model();
            chk("ce_low_pulse", 8'(tick[0]), 8'd0);
        end
        ce = 1'b1;
        for (int n = 0; n < 10; n++) begin step(); check_model(); end

        // ---- P=0 pulse mode gives a constant-high tick
        load = 1'b1; ld_ch = 2'd2; ld_div = 8'd0; ld_mode = 1'b0; ld_imm = 1'b1;
        step();
        load = 1'b0;
        chk("p0_load_clear", 8'(tick[2]), 8'd0);
        for (int n = 0; n < 5; n++) begin
            step();
            chk("p0_const_high", 8'(tick[2]), 8'd1);
        end

        // ---- disabling a channel flushes its pending shadow
        load = 1'b1; ld_ch = 2'd0; ld_div = 8'd3; ld_mode = 1'b1; ld_imm = 1'b0;
        step();
        load = 1'b0;
        chk("dis_pend_set", 8'(pend[0]), 8'd1);
        chen[0] = 1'b0;
        step();
        chk("dis_pend_clear", 8'(pend[0]), 8'd0);
        chk("dis_out_low", 8'(tick[0]), 8'd0);
        chen = '1;
        for (int n = 0; n < 8; n++) begin step(); check_model(); end

        // ---- reset while ch1 is pending and its square output is high
        found = 1'b0;
        prev  = tick[1];
        for (int n = 0; n < 12 && !found; n++) begin
            step(); check_model();
            if (!prev && tick[1]) found = 1'b1;
            prev = tick[1];
        end
        chk("wait_sq_rise", 8'(found), 8'd1);
        load = 1'b1; ld_ch = 2'd1; ld_div = 8'd5; ld_mode = 1'b1; ld_imm = 1'b0;
        step();
        chk("rst_pre_pend", 8'(pend[1]), 8'd1);
        chk("rst_pre_sq",   8'(tick[1]), 8'd1);
        rst = 1'b1; ld_ch = 2'd0; ld_div = 8'd9; ld_imm = 1'b1;
        step();
        chk("rst_tick", 8'(tick), 8'd0);
        chk("rst_pend", 8'(pend), 8'd0);
        chk("rst_ack",  8'(ack),  8'd0);
        rst = 1'b0; load = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("post_rst_quiet", 8'(tick), 8'd0);
        end
        step();
        chk("post_rst_first_pulse", 8'(tick), 8'(3'b111));

        // ---- randomized traffic against the reference model
        for (int n = 0; n < 800; n++) begin
            rst     = ($urandom_range(0, 99) == 0);
            ce      = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < CH; c++) chen[c] = ($urandom_range(0, 15) != 0);
            load    = ($urandom_range(0, 5) == 0);
            ld_ch   = 2'($urandom_range(0, 3));
            ld_div  = 8'($urandom_range(0, 6));
            ld_mode = 1'($urandom_range(0, 1));
            ld_imm  = 1'($urandom_range(0, 1));
            step();
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/divisor_multi.md
# divisor_multi

Multi-channel, runtime-programmable clock-enable generator; successor to the fixed 24-bit single-tick divisor. Each channel derives a one-cycle tick or a 50 % square enable from iClk with a period loaded at run time. Loads are either immediate or deferred to the next wrap so the period changes without glitches. It sits between the system clock and the spirometer sampling, display-refresh and UART-pacing logic; one instance serves all of them.

## Interface
- WIDTH, 24: counter/period width in bits.
- CHANNELS, 2: number of independent channels (≥1).
- DEFAULT_DIV, 12500000: terminal value loaded into every channel at reset.
- iClk  in  1  system clock; all logic on rising edge.
- iReset  in  1  synchronous, active-high reset.
- iCE  in  1  global count enable; 0 freezes all counters.
- ivChEn  in  CHANNELS  per-channel enable.
- iLoad  in  1  load strobe, one cycle, sampled every cycle.
- ivLoadCh  in  max(1,$clog2(CHANNELS))  target channel of the load.
- ivLoadDiv  in  WIDTH  new terminal value P.
- iLoadMode  in  1  new mode: 0 = pulse, 1 = square.
- iLoadImm  in  1  1 = apply now, 0 = apply at next wrap.
- ovTick  out  CHANNELS  per-channel output (pulse or square, per mode).
- ovPending  out  CHANNELS  deferred load waiting for wrap.
- oLoadAck  out  1  one-cycle acknowledge of any accepted load.

## Operation
- Per channel, the state is: count[WIDTH], div[WIDTH], mode, shadow div/mode, pending, out.
- Counting (iCE=1, enabled): count runs 0..div. When count==div, the count returns to 0 and a terminal event fires. The period is div+1 cycles, so the legacy value 12500000 gives 12500001 cycles.
- Pulse mode: out is registered. It is 1 for exactly the cycle after the terminal cycle (count==0 after the wrap), and 0 otherwise.
- Square mode: out toggles on each terminal event, giving a period of 2·(div+1).
- div=0: a terminal event fires every cycle. Pulse out stays at constant 1; square out toggles every cycle.
- iCE=0: count, div, square out and pending are held. Pulse out is forced to 0, so no stretched ticks.
- ivChEn[i]=0: count←0 and out←0. Any pending shadow is applied immediately and pending←0.
- iLoad with ivLoadCh ≥ CHANNELS is ignored: no ack.
- Immediate load (iLoadImm=1): next cycle div←ivLoadDiv, mode←iLoadMode, count←0, out←0, pending←0. Any previously pending shadow is discarded.
- Deferred load (iLoadImm=0): next cycle shadow←{div,mode} and pending←1. On the next terminal event, div/mode←shadow and pending←0 in the same cycle the count wraps to 0. out behaves per the new mode from then on; square out is cleared to 0 at a mode change.
- A deferred load to an already-pending channel overwrites the shadow (last wins).
- Deferred loads are accepted while iCE=0 and wait for the wrap. Immediate loads take effect regardless of iCE.
- A load coinciding with that channel's terminal event: the wrap uses the old values. A deferred load is then applied at the following wrap.

## Timing
- Reset values: count=0, div=DEFAULT_DIV, mode=pulse, pending=0, ovTick=0, ovPending=0, oLoadAck=0.
- Reset has priority over iLoad and iCE.
- Reset mid-operation restores defaults in one cycle and discards shadows.
- oLoadAck is 1 in the cycle after iLoad is sampled (1-cycle latency); there is no backpressure.
- ovPending rises the cycle after a deferred iLoad.
- First pulse after reset: ovTick high at cycle DEFAULT_DIV+2 after reset deasserts (count runs 0..DEFAULT_DIV, then the registered tick).
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package divisor_pkg holds: MODE_PULSE=1'b0, MODE_SQUARE=1'b1, DEFAULT_DIV, and the channel-select width helper.
- Sub-module divisor_channel: one counter/shadow/output slice (~100 lines), instantiated CHANNELS times via generate.
- The top level (divisor_multi) contains the load decode, range check and ack register.

## Test plan
- WIDTH=8, DEFAULT_DIV=4, reset then iCE=1 -> ovTick[0] and ovTick[1] pulse once every 5 cycles; first pulse at cycle 6; ovPending=0.
- Immediate load ch1 P=2, square, at arbitrary count -> next cycle count=0, out=0; ovTick[1] toggles every 3 cycles; oLoadAck high one cycle; ch0 undisturbed.
- Deferred load ch0 P=7 mid-period -> ovPending[0]=1 until the wrap; the old 5-cycle period completes, then pulses every 8 cycles. A second deferred load (P=1) before the wrap -> P=1 is applied instead.
- iCE low for 10 cycles starting in a pulse cycle -> pulse drops to 0 immediately, counts freeze, and the sequence resumes exactly when iCE returns; square level is held.
- P=0 in pulse mode -> ovTick constant 1. Load to ch index 3 with CHANNELS=2 -> ignored, no ack. ivChEn[0]=0 with pending -> shadow applied, pending clears, out=0.
- iReset asserted during pending, square high -> all outputs 0, div=DEFAULT_DIV the next cycle; reset overrides a simultaneous iLoad.
